sha3512_digest_streamer: RTL and testbench



---
 rtl/sha3512_pkg.sv | 38 +++
 rtl/sha3512_word_mux.sv | 52 +++++
 rtl/sha3512_digest_streamer.sv | 144 ++++++++++++++
 tb/tb_sha3512_digest_streamer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3512_pkg.sv
// -----------------------------------------------------------------------------
// sha3512_pkg
//
// Shared definitions for the SHA3-512 output path.
//   - Keccak state / output register / digest widths.
//   - stream_state_t: state encoding of the digest streamer FSM.
//   - byte_swap(): reverses the byte order inside a lane of up to 64 bits.
//
// Optional build macro used by files importing this package:
//   SHA3512_STREAM_BYTESWAP_EN  (byte-reverse each streamed beat)
// -----------------------------------------------------------------------------
package sha3512_pkg;

  localparam int SHA3_STATE_W  = 1600;
  localparam int SHA3_OUT_W    = 576;
  localparam int SHA3_DIGEST_W = 512;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Reverse the order of the lowest nbytes bytes of w. Byte 0 of the lane
  // lands in the most significant byte position of the nbytes-wide result.
  // Bits above nbytes*8 in the result are zero.
  function automatic logic [63:0] byte_swap(input logic [63:0] w,
                                            input int          nbytes);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) begin
        r[8*(nbytes-1-i) +: 8] = w[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage : sha3512_pkg

// File: rtl/sha3512_word_mux.sv
// -----------------------------------------------------------------------------
// sha3512_word_mux
//
// Combinational beat selector: picks word number `cnt` out of the captured
// digest (least-significant word first) and optionally byte-reverses it.
//
// Build macro: SHA3512_STREAM_BYTESWAP_EN
//   defined   -> byte 0 of the lane goes to word[WORD_W-1:WORD_W-8]
//   undefined -> lane bytes pass through in keccak little-endian order
//
// Ports:
//   capture  input  DIGEST_W  captured digest
//   cnt      input  CNT_W     beat index, always < DIGEST_W/WORD_W
//   word     output WORD_W    selected (and optionally swapped) beat
// -----------------------------------------------------------------------------
module sha3512_word_mux
  import sha3512_pkg::*;
#(
  parameter int WORD_W   = 64,
  parameter int DIGEST_W = 512,
  parameter int CNT_W    = 3
) (
  input  logic [DIGEST_W-1:0] capture,
  input  logic [CNT_W-1:0]    cnt,
  output logic [WORD_W-1:0]   word
);

  logic [WORD_W-1:0] word_raw;

  // The counter never exceeds NBEATS-1, so the indexed slice stays in range.
  always_comb begin
    word_raw = capture[int'(cnt)*WORD_W +: WORD_W];
  end

`ifdef SHA3512_STREAM_BYTESWAP_EN
  logic [63:0] lane_ext;
  logic [63:0] lane_swapped;

  // Zero-extend to the 64-bit helper width, swap, then take the low WORD_W.
  always_comb begin
    lane_ext               = '0;
    lane_ext[WORD_W-1:0]   = word_raw;
    lane_swapped           = byte_swap(lane_ext, WORD_W / 8);
    word                   = lane_swapped[WORD_W-1:0];
  end
`else
  always_comb begin
    word = word_raw;
  end
`endif

endmodule : sha3512_word_mux

// File: rtl/sha3512_digest_streamer.sv
// -----------------------------------------------------------------------------
// sha3512_digest_streamer
//
// Captures the 512-bit digest from the low bits of the 576-bit coprocessor
// output register and serialises it as NBEATS beats of WORD_W bits over a
// valid/ready stream, least-significant word first.
//
// Handshake: a beat transfers on a rising edge where outValid && inReady.
// Once outValid is high it stays high, with outWord/outLast held stable,
// until that beat transfers; valid is never withdrawn by the streamer.
//
// Build macro: SHA3512_STREAM_BYTESWAP_EN (byte-reverse each beat).
//
// Ports:
//   inClk       input   1        clock, rising edge
//   inRstN      input   1        asynchronous active-low reset
//   inInit      input   1        synchronous clear, aborts any stream
//   inStart     input   1        digest on inData valid this cycle
//   inData      input   576      output register, bits 575:512 ignored
//   inReady     input   1        consumer ready
//   outValid    output  1        beat valid
//   outWord     output  WORD_W   beat data
//   outLast     output  1        final beat marker
//   outBusy     output  1        a digest is held
//   outDone     output  1        pulse the cycle after the final transfer
//   outOverrun  output  1        sticky: inStart arrived while busy
//   outState    output  1        FSM state (debug visibility)
// -----------------------------------------------------------------------------
module sha3512_digest_streamer
  import sha3512_pkg::*;
#(
  parameter int WORD_W   = 64,
  parameter int DIGEST_W = SHA3_DIGEST_W,
  parameter int NBEATS   = DIGEST_W / WORD_W
) (
  input  logic                  inClk,
  input  logic                  inRstN,
  input  logic                  inInit,
  input  logic                  inStart,
  input  logic [SHA3_OUT_W-1:0] inData,
  input  logic                  inReady,
  output logic                  outValid,
  output logic [WORD_W-1:0]     outWord,
  output logic                  outLast,
  output logic                  outBusy,
  output logic                  outDone,
  output logic                  outOverrun,
  output stream_state_t         outState
);

  localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  stream_state_t       state;
  logic [CNT_W-1:0]    cnt;
  logic [DIGEST_W-1:0] capture;
  logic                done_q;
  logic                overrun_q;

  logic                is_last;
  logic                xfer;
  logic                final_xfer;
  logic [WORD_W-1:0]   mux_word;

  // Padding bits of the output register are deliberately not used.
  logic unused_pad;
  assign unused_pad = ^inData[SHA3_OUT_W-1:DIGEST_W];

  assign is_last    = (state == STREAM) && (cnt == LAST_CNT);
  assign xfer       = (state == STREAM) && inReady;
  assign final_xfer = xfer && is_last;

  sha3512_word_mux #(
    .WORD_W   (WORD_W),
    .DIGEST_W (DIGEST_W),
    .CNT_W    (CNT_W)
  ) u_word_mux (
    .capture (capture),
    .cnt     (cnt),
    .word    (mux_word)
  );

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state     <= IDLE;
      cnt       <= '0;
      capture   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (inInit) begin
      // Clear wins over everything, including a coincident inStart.
      state     <= IDLE;
      cnt       <= '0;
      capture   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= final_xfer;
      case (state)
        IDLE: begin
          if (inStart) begin
            capture <= inData[DIGEST_W-1:0];
            cnt     <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (final_xfer) begin
            cnt <= '0;
            // A start on the final transfer chains straight into a new
            // digest with no idle bubble.
            if (inStart) begin
              capture <= inData[DIGEST_W-1:0];
              state   <= STREAM;
            end else begin
              state   <= IDLE;
            end
          end else begin
            if (xfer) begin
              cnt <= cnt + CNT_W'(1);
            end
            // Any other start while a digest is held is dropped and flagged.
            if (inStart) begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign outValid   = (state == STREAM);
  assign outBusy    = (state == STREAM);
  assign outLast    = is_last;
  assign outWord    = (state == STREAM) ? mux_word : '0;
  assign outDone    = done_q;
  assign outOverrun = overrun_q;
  assign outState   = state;

endmodule : sha3512_digest_streamer

// File: tb/tb_sha3512_digest_streamer.sv
// -----------------------------------------------------------------------------
// tb_sha3512_digest_streamer
//
// Self-checking bench for sha3512_digest_streamer at default parameters.
// Reference model: a queue of beats still owed to the consumer, refilled on
// each accepted inStart, popped on each transfer.
// -----------------------------------------------------------------------------
module tb_sha3512_digest_streamer;
  import sha3512_pkg::*;

  localparam int WORD_W   = 64;
  localparam int DIGEST_W = 512;
  localparam int NBEATS   = DIGEST_W / WORD_W;

`ifdef SHA3512_STREAM_BYTESWAP_EN
  localparam logic [63:0] BEAT0_LIT = 64'h0001020304050607;
`else
  localparam logic [63:0] BEAT0_LIT = 64'h0706050403020100;
`endif

  logic                  inClk;
  logic                  inRstN;
  logic                  inInit;
  logic                  inStart;
  logic [SHA3_OUT_W-1:0] inData;
  logic                  inReady;
  logic                  outValid;
  logic [WORD_W-1:0]     outWord;
  logic                  outLast;
  logic                  outBusy;
  logic                  outDone;
  logic                  outOverrun;
  stream_state_t         outState;

  int checks;
  int errors;
  int xfer_cnt;
  int last_cnt;
  int done_cnt;

  logic [WORD_W-1:0] exp_q[$];
  logic              m_done;
  logic              m_overrun;

  sha3512_digest_streamer #(
    .WORD_W   (WORD_W),
    .DIGEST_W (DIGEST_W)
  ) dut (
    .inClk      (inClk),
    .inRstN     (inRstN),
    .inInit     (inInit),
    .inStart    (inStart),
    .inData     (inData),
    .inReady    (inReady),
    .outValid   (outValid),
    .outWord    (outWord),
    .outLast    (outLast),
    .outBusy    (outBusy),
    .outDone    (outDone),
    .outOverrun (outOverrun),
    .outState   (outState)
  );

  // ---------------- clock ----------------
  initial begin
    inClk = 1'b0;
    forever #5 inClk = ~inClk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat b of a digest: word b of the low DIGEST_W bits, bytes
  // reversed within the word when the swap build is selected.
  function automatic logic [WORD_W-1:0] beat_of(input logic [SHA3_OUT_W-1:0] d,
                                                input int b);
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] s;
    w = d[b*WORD_W +: WORD_W];
`ifdef SHA3512_STREAM_BYTESWAP_EN
    for (int j = 0; j < WORD_W / 8; j++) begin
      s[WORD_W-8-8*j +: 8] = w[8*j +: 8];
    end
`else
    s = w;
`endif
    return s;
  endfunction

  function automatic logic [SHA3_OUT_W-1:0] rand_data();
    logic [SHA3_OUT_W-1:0] r;
    for (int i = 0; i < SHA3_OUT_W / 32; i++) begin
      r[32*i +: 32] = $urandom();
    end
    return r;
  endfunction

  task automatic load_digest(input logic [SHA3_OUT_W-1:0] d);
    exp_q.delete();
    for (int b = 0; b < NBEATS; b++) begin
      exp_q.push_back(beat_of(d, b));
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge inClk or negedge inRstN) begin
    int  n;
    bit  fin;
    if (!inRstN) begin
      exp_q.delete();
      m_done    = 1'b0;
      m_overrun = 1'b0;
    end else if (inInit) begin
      exp_q.delete();
      m_done    = 1'b0;
      m_overrun = 1'b0;
    end else begin
      n      = exp_q.size();
      fin    = (n == 1) && inReady;
      m_done = fin;
      if (n > 0 && inReady) begin
        void'(exp_q.pop_front());
      end
      if (inStart) begin
        if (n == 0 || fin) load_digest(inData);
        else               m_overrun = 1'b1;
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  always @(negedge inClk) begin
    logic exp_valid;
    exp_valid = (exp_q.size() > 0);
    check("valid",   outValid,   exp_valid);
    check("busy",    outBusy,    exp_valid);
    check("state",   outState,   exp_valid ? STREAM : IDLE);
    check("last",    outLast,    exp_valid && (exp_q.size() == 1));
    check("done",    outDone,    m_done);
    check("overrun", outOverrun, m_overrun);
    if (exp_valid) check("word", outWord, exp_q[0]);
    if (outValid && inReady) begin
      xfer_cnt++;
      if (outLast) last_cnt++;
    end
    if (outDone) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic clear_counts();
    xfer_cnt = 0;
    last_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_digest(input logic [SHA3_OUT_W-1:0] d);
    inData  = d;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    inData  = rand_data();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [SHA3_OUT_W-1:0] pat;
    logic [SHA3_OUT_W-1:0] da;
    logic [SHA3_OUT_W-1:0] db;

    checks = 0;
    errors = 0;
    clear_counts();
    inRstN  = 1'b0;
    inInit  = 1'b0;
    inStart = 1'b0;
    inData  = '0;
    inReady = 1'b0;
    repeat (3) @(posedge inClk);
    #1;
    check("rst_valid",   outValid,   1'b0);
    check("rst_word",    outWord,    '0);
    check("rst_last",    outLast,    1'b0);
    check("rst_busy",    outBusy,    1'b0);
    check("rst_done",    outDone,    1'b0);
    check("rst_overrun", outOverrun, 1'b0);
    inRstN = 1'b1;
    tick();

    // 1: plain streaming, byte i of the digest = i, padding random
    pat = rand_data();
    for (int i = 0; i < 64; i++) pat[8*i +: 8] = 8'(i);
    inReady = 1'b1;
    start_digest(pat);
    clear_counts();
    check("t1_latency",     outValid, 1'b1);
    check("t1_beat0",       outWord,  BEAT0_LIT);
    check("t1_model_beat0", exp_q[0], BEAT0_LIT);
    repeat (10) tick();
    check("t1_xfers", 32'(xfer_cnt), 32'd8);
    check("t1_lasts", 32'(last_cnt), 32'd1);
    check("t1_dones", 32'(done_cnt), 32'd1);
    check("t1_idle",  outBusy, 1'b0);

    // 2: backpressure, ready pattern 1,0,0 repeating
    start_digest(rand_data());
    clear_counts();
    for (int k = 0; k < 36; k++) begin
      inReady = (k % 3 == 0);
      tick();
    end
    inReady = 1'b1;
    repeat (2) tick();
    check("t2_xfers", 32'(xfer_cnt), 32'd8);
    check("t2_dones", 32'(done_cnt), 32'd1);

    // 3: overrun at beat 3, then init (with a coincident ignored start)
    da = rand_data();
    start_digest(da);
    repeat (3) tick();
    start_digest(rand_data());
    check("t3_overrun_set", outOverrun, 1'b1);
    check("t3_keeps_a",     outWord,    beat_of(da, 4));
    repeat (6) tick();
    check("t3_overrun_sticky", outOverrun, 1'b1);
    start_digest(rand_data());
    repeat (4) tick();
    inInit = 1'b1;
    start_digest(rand_data());
    inInit = 1'b0;
    check("t3_init_overrun", outOverrun, 1'b0);
    check("t3_init_valid",   outValid,   1'b0);
    tick();
    check("t3_start_ignored", outValid, 1'b0);

    // 4: back-to-back, second start on the beat-7 transfer
    start_digest(rand_data());
    repeat (7) tick();
    check("t4_last", outLast, 1'b1);
    db = rand_data();
    start_digest(db);
    check("t4_done",    outDone,    1'b1);
    check("t4_valid",   outValid,   1'b1);
    check("t4_beat0",   outWord,    beat_of(db, 0));
    check("t4_overrun", outOverrun, 1'b0);
    repeat (9) tick();

    // 5: asynchronous reset at beat 5
    start_digest(rand_data());
    repeat (5) tick();
    #2;
    inRstN = 1'b0;
    #1;
    check("t5_valid",   outValid,   1'b0);
    check("t5_word",    outWord,    '0);
    check("t5_last",    outLast,    1'b0);
    check("t5_busy",    outBusy,    1'b0);
    check("t5_done",    outDone,    1'b0);
    check("t5_overrun", outOverrun, 1'b0);
    @(posedge inClk);
    #1;
    inRstN = 1'b1;
    da = rand_data();
    start_digest(da);
    check("t5_restart", outWord, beat_of(da, 0));
    repeat (10) tick();

    // 6: random traffic
    for (int c = 0; c < 600; c++) begin
      inReady = ($urandom_range(0, 3) != 0);
      inStart = ($urandom_range(0, 9) == 0);
      inInit  = ($urandom_range(0, 149) == 0);
      inData  = rand_data();
      tick();
    end
    inStart = 1'b0;
    inInit  = 1'b0;
    inReady = 1'b1;
    repeat (12) tick();
    check("t6_drained", outValid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sha3512_digest_streamer
